// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer write arbiter bus: two write requesters, swap handshake and the
// registered ping-pong buffer write port. master = requester side, slave = arbiter.
interface fb_write_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              frameStart;
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic              gnt0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic              gnt1;
    logic              swap_req;
    logic              swap_ack;
    logic              we;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              swap;
    logic              addr_err;
    logic [15:0]       frame_writes;

    modport master (
        output frameStart, req0, addr0, data0, req1, addr1, data1, swap_req,
        input  gnt0, gnt1, swap_ack, we, wrAddr, wrData, swap, addr_err, frame_writes
    );

    modport slave (
        input  frameStart, req0, addr0, data0, req1, addr1, data1, swap_req,
        output gnt0, gnt1, swap_ack, we, wrAddr, wrData, swap, addr_err, frame_writes
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Two-requester frame-buffer write arbiter with frame-synchronous ping-pong swap.
// Define FB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module fb_write_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 768
) (
    input logic              vgaclk,
    input logic              rst,
    fb_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, SWAP, ACK} state_t;

    state_t            state_q, state_d;
    logic              gnt0, gnt1, gnt_any, in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              addr_err_q, addr_err_d;
    logic [15:0]       wcnt_q, wcnt_d, wcnt_inc;
    logic [15:0]       frame_writes_q, frame_writes_d;

`ifndef FB_ARB_FIXED_PRIO_EN
    // Set when requester 1 should win the next tie.
    logic prio1_q, prio1_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            IDLE:    if (bus.swap_req)   state_d = ARMED;
            ARMED:   if (bus.frameStart) state_d = SWAP;
            SWAP:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // No grants during reset or the swap cycle, so nothing lands on the new buffer early.
        if (!rst && state_q != SWAP) begin
`ifdef FB_ARB_FIXED_PRIO_EN
            gnt0 = bus.req0;
            gnt1 = bus.req1 && !bus.req0;
`else
            gnt0 = bus.req0 && (!bus.req1 || !prio1_q);
            gnt1 = bus.req1 && (!bus.req0 || prio1_q);
`endif
        end
    end

`ifndef FB_ARB_FIXED_PRIO_EN
    always_comb begin
        prio1_d = prio1_q;
        if (gnt0)      prio1_d = 1'b1;
        else if (gnt1) prio1_d = 1'b0;
    end

    always_ff @(posedge vgaclk) begin
        if (rst) prio1_q <= 1'b0;
        else     prio1_q <= prio1_d;
    end
`endif

    always_comb begin
        gnt_any  = gnt0 || gnt1;
        sel_addr = gnt1 ? bus.addr1 : bus.addr0;
        sel_data = gnt1 ? bus.data1 : bus.data0;
        in_range = 32'(sel_addr) < 32'(DEPTH);

        we_d       = gnt_any && in_range;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        addr_err_d = addr_err_q || (gnt_any && !in_range);
        if (gnt_any && in_range) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end

        // A write on we this cycle is committed now, including during SWAP.
        wcnt_inc       = (we_q && wcnt_q != 16'hFFFF) ? wcnt_q + 16'd1 : wcnt_q;
        wcnt_d         = wcnt_inc;
        frame_writes_d = frame_writes_q;
        if (state_q == SWAP) begin
            frame_writes_d = wcnt_inc;
            wcnt_d         = 16'd0;
        end
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            addr_err_q     <= 1'b0;
            wcnt_q         <= 16'd0;
            frame_writes_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            addr_err_q     <= addr_err_d;
            wcnt_q         <= wcnt_d;
            frame_writes_q <= frame_writes_d;
        end
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.we           = we_q;
    assign bus.wrAddr       = wr_addr_q;
    assign bus.wrData       = wr_data_q;
    assign bus.swap         = (state_q == SWAP);
    assign bus.swap_ack     = (state_q == ACK);
    assign bus.addr_err     = addr_err_q;
    assign bus.frame_writes = frame_writes_q;
endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the width of the frame-buffer address.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the packed 3:3:2 pixel width.
REQ-003 The block SHALL have parameter DEPTH, default 768, meaning the number of valid buffer entries.
REQ-004 vgaclk  input  1  pixel clock, the only clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 frameStart  input  1  single-cycle pulse at hc==0, vc==0.
REQ-007 req0 / addr0 / data0  input  1 / ADDR_W / DATA_W  requester 0 (graphics) write request, address and data.
REQ-008 gnt0  output  1  requester 0 write accepted this cycle.
REQ-009 req1 / addr1 / data1  input  1 / ADDR_W / DATA_W  requester 1 (host loader) write request, address and data.
REQ-010 gnt1  output  1  requester 1 write accepted this cycle.
REQ-011 swap_req  input  1  level request to swap the ping-pong buffers; held until swap_ack.
REQ-012 swap_ack  output  1  one-cycle acknowledge that the swap has been issued.
REQ-013 we / wrAddr / wrData  output  1 / ADDR_W / DATA_W  registered write port to the ping-pong buffer.
REQ-014 swap  output  1  one-cycle buffer-swap strobe to the ping-pong buffer.
REQ-015 addr_err  output  1  sticky flag: a granted write had an address >= DEPTH.
REQ-016 frame_writes  output  16  count of writes committed in the previous frame.

Function
REQ-017 Grants SHALL be combinational from req0/req1 and the current state; at most one of gnt0/gnt1 SHALL be high in any cycle.
REQ-018 Arbitration SHALL be round-robin: when both requesters are asserted, the grant goes to the requester not granted most recently; after reset, requester 0 has priority.
REQ-019 A granted write SHALL appear on we/wrAddr/wrData exactly 1 cycle after the grant (registered output).
REQ-020 we SHALL be low in every cycle not preceded by a grant.
REQ-021 A granted write with address >= DEPTH SHALL be dropped (we stays low), SHALL set addr_err, and SHALL still count as granted to the requester.
REQ-022 The swap FSM SHALL have states IDLE, ARMED, SWAP and ACK.
REQ-023 IDLE -> ARMED when swap_req is high.
REQ-024 ARMED -> SWAP on the first frameStart seen while in ARMED; a frameStart in the same cycle as the IDLE->ARMED transition SHALL NOT count.
REQ-025 SWAP lasts 1 cycle: swap=1, gnt0=gnt1=0; then the FSM moves to ACK.
REQ-026 ACK lasts 1 cycle: swap_ack=1; then the FSM moves to IDLE.
REQ-027 A write granted in the cycle before SWAP SHALL still commit on we during the SWAP cycle, before the swap takes effect.
REQ-028 An internal 16-bit write counter SHALL increment once per committed write and SHALL saturate at 0xFFFF.
REQ-029 On swap=1, frame_writes SHALL load the counter value including any write committed in that same cycle, and the counter SHALL clear to 0.
REQ-030 swap_req deasserted while in ARMED SHALL NOT cancel the pending swap.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE and the following SHALL be cleared: we=0, wrAddr=0, wrData=0, swap=0, swap_ack=0, addr_err=0, frame_writes=0, counter=0, round-robin pointer = requester 0.
REQ-032 While rst is high, gnt0 and gnt1 SHALL be 0.
REQ-033 A reset asserted in ARMED or SWAP SHALL abandon the swap with no swap_ack.

Configuration
REQ-034 With macro FB_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority with requester 0 always winning; the round-robin pointer SHALL NOT exist.
REQ-035 Without FB_ARB_FIXED_PRIO_EN, REQ-018 round-robin behaviour SHALL apply.

Verification
REQ-036 req0=1, addr0=5, data0=0xE3, req1=0 -> gnt0=1 the same cycle; next cycle we=1, wrAddr=5, wrData=0xE3.
REQ-037 req0=req1=1 held for 4 cycles after reset (round-robin build) -> grants alternate 0,1,0,1; with FB_ARB_FIXED_PRIO_EN -> gnt0 in all 4 cycles.
REQ-038 req1=1, addr1=800 -> gnt1=1, next cycle we=0, addr_err=1 and stays 1 until rst.
REQ-039 10 writes committed, swap_req=1, frameStart pulse 3 cycles later -> swap=1 for 1 cycle with gnt0/gnt1 low, swap_ack=1 the following cycle, frame_writes=10.
REQ-040 swap_req=1 and frameStart=1 in the same cycle from IDLE -> no swap; swap occurs on the next frameStart.
REQ-041 rst asserted while in ARMED -> swap_ack never asserts, all outputs read 0 the cycle after rst.
